// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes on the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit; line idles high.
//
//   state | meaning
//   IDLE  | line high, waiting for T_EN; Transmit_Done pulses here after a frame
//   START | start bit (low) for one bit period
//   DATA  | data bits 0..7, LSB first, one bit period each
//   STOP  | stop bit (high) for one bit period
module uart_transmit
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       T_EN,
    input  logic [7:0] Data,
    output logic       Serial,
    output logic       Transmit_Done
);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        serial_q;
    logic        done_q;
    logic        bit_end;

    // Holding the counter clear in IDLE guarantees START begins at count 0.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i    (Clk),
        .rst_ni   (reset),
        .clear_i  (state_q == IDLE),
        .bit_end_o(bit_end)
    );

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    serial_q <= 1'b1;
                    if (T_EN) begin
                        shift_q   <= Data;
                        bit_idx_q <= '0;
                        serial_q  <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        serial_q <= shift_q[0];
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            serial_q <= 1'b1;
                            state_q  <= STOP;
                        end else begin
                            // Serial presents the next bit while the register shifts it down.
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            serial_q  <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Serial        = serial_q;
    assign Transmit_Done = done_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Scoreboard bench for uart_transmit with a 4-cycle bit period.
`timescale 1ns/10ps
module tb_uart_transmit;

    localparam int N = 4;

    logic       Clk = 1'b0;
    logic       reset;
    logic       T_EN;
    logic [7:0] Data;
    logic       Serial;
    logic       Transmit_Done;

    uart_transmit #(.CLKS_PER_BIT(N)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .T_EN         (T_EN),
        .Data         (Data),
        .Serial       (Serial),
        .Transmit_Done(Transmit_Done)
    );

    always #1 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int         falls[$];
    int         frames_seen = 0;
    int         aborts = 0;
    int         done_pulses = 0;
    int         cyc = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    // Monitor: detects a start edge, samples mid-bit, compares with the scoreboard.
    initial begin : monitor
        logic       prev_ser;
        logic [9:0] bits;
        logic [7:0] exp;
        logic       aborted;
        logic       done_early;
        logic       have_exp;
        prev_ser = 1'b1;
        forever begin
            @(negedge Clk);
            cyc++;
            if (reset && prev_ser && !Serial) begin
                falls.push_back(cyc);
                have_exp = (exp_q.size() != 0);
                exp = have_exp ? exp_q.pop_front() : 8'h00;
                if (!have_exp) check("unexpected_frame", 1, 0);
                bits = '0;
                aborted = 1'b0;
                done_early = 1'b0;
                for (int c = 1; c <= 10 * N; c++) begin
                    @(negedge Clk);
                    cyc++;
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c < 10 * N) begin
                        if (Transmit_Done) done_early = 1'b1;
                        if (c % N == N / 2) bits[c / N] = Serial;
                    end
                end
                if (aborted) begin
                    aborts++;
                end else if (have_exp) begin
                    check("start_bit", int'(bits[0]), 0);
                    check("data_byte", int'(bits[8:1]), int'(exp));
                    check("stop_bit", int'(bits[9]), 1);
                    check("done_early", int'(done_early), 0);
                    check("done_at_frame_end", int'(Transmit_Done), 1);
                    check("line_high_after_frame", int'(Serial), 1);
                end
                frames_seen++;
            end
            prev_ser = Serial;
        end
    end

    // Transmit_Done must never stay high for two consecutive cycles.
    initial begin : done_mon
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge Clk);
            if (Transmit_Done && !prev_done) done_pulses++;
            if (Transmit_Done && prev_done) check("done_pulse_width", 2, 1);
            prev_done = Transmit_Done;
        end
    end

    // Inputs change shortly after the falling edge, away from both sampling points.
    task automatic step();
        @(negedge Clk);
        #0.2;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_seen < target && n < 2000) begin
            step();
            n++;
        end
        if (frames_seen < target) check("frame_timeout", frames_seen, target);
    endtask

    initial begin : stim
        int d0;
        int d1;
        reset = 1'b0;
        T_EN  = 1'b0;
        Data  = 8'h00;

        // Reset held: line high, no done.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_serial", int'(Serial), 1);
            check("reset_done", int'(Transmit_Done), 0);
        end

        // Single byte 0x83 with a one-cycle enable.
        reset = 1'b1;
        step();
        Data = 8'h83;
        exp_q.push_back(8'h83);
        T_EN = 1'b1;
        step();
        T_EN = 1'b0;
        wait_frames(1);
        check("pulses_after_single", done_pulses, 1);

        // Enable held: three back-to-back frames, 41 cycles apart.
        repeat (4) step();
        Data = 8'h83;
        repeat (3) exp_q.push_back(8'h83);
        T_EN = 1'b1;
        repeat (90) step();
        T_EN = 1'b0;
        wait_frames(4);
        d0 = falls[falls.size() - 2] - falls[falls.size() - 3];
        d1 = falls[falls.size() - 1] - falls[falls.size() - 2];
        check("b2b_period_1", d0, 10 * N + 1);
        check("b2b_period_2", d1, 10 * N + 1);
        check("pulses_after_b2b", done_pulses, 4);

        // Data changed mid-frame only affects the following frame.
        repeat (4) step();
        Data = 8'h83;
        exp_q.push_back(8'h83);
        exp_q.push_back(8'h55);
        T_EN = 1'b1;
        repeat (10) step();
        Data = 8'h55;
        repeat (40) step();
        T_EN = 1'b0;
        wait_frames(6);

        // Reset during D3 aborts the frame; reset beats a simultaneous enable.
        repeat (4) step();
        Data = 8'h3C;
        exp_q.push_back(8'h3C);
        T_EN = 1'b1;
        step();
        T_EN = 1'b0;
        repeat (17) step();
        reset = 1'b0;
        step();
        check("abort_serial_high", int'(Serial), 1);
        check("abort_no_done", int'(Transmit_Done), 0);
        T_EN = 1'b1;
        repeat (2) begin
            step();
            check("reset_wins_serial", int'(Serial), 1);
            check("reset_wins_done", int'(Transmit_Done), 0);
        end
        check("abort_count", aborts, 1);
        Data = 8'hA5;
        exp_q.push_back(8'hA5);
        reset = 1'b1;
        step();
        T_EN = 1'b0;
        wait_frames(8);
        check("pulses_after_abort", done_pulses, 7);

        // All-zero and all-one payloads.
        repeat (4) step();
        Data = 8'h00;
        exp_q.push_back(8'h00);
        T_EN = 1'b1;
        step();
        T_EN = 1'b0;
        wait_frames(9);
        repeat (4) step();
        Data = 8'hFF;
        exp_q.push_back(8'hFF);
        T_EN = 1'b1;
        step();
        T_EN = 1'b0;
        wait_frames(10);

        repeat (4) step();
        check("total_done_pulses", done_pulses, 9);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
